// File: rtl/fetch_pc_unit_pkg.sv
// Shared types for the LC-3b instruction-fetch stage.
//   lc3b_word     : 16-bit machine word (instructions and addresses)
//   fetch_state_t : fetch controller state encoding
//   fetch_word_t  : an instruction together with the address it came from
//   pc_incr()     : next sequential PC, 16-bit wrap with no carry out
package fetch_pc_unit_pkg;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_FETCH   = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    lc3b_word instr;
    lc3b_word pc;
  } fetch_word_t;

  localparam lc3b_word PC_STEP = 16'd2;

  function automatic lc3b_word pc_incr(input lc3b_word pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_hold_buffer.sv
// Single-entry capture register for a response that arrives while the
// downstream pipeline is stalled.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   load         : capture 'capture' and mark the entry valid
//   clear        : invalidate the entry (takes priority over load)
//   capture      : {instr, pc} to store
//   valid        : entry holds a captured response
//   word         : stored {instr, pc}
module fetch_pc_unit_hold_buffer
  import fetch_pc_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        clear,
  input  fetch_word_t capture,
  output logic        valid,
  output fetch_word_t word
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      word  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= capture;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// LC-3b instruction-fetch stage. Owns the PC, runs the I-cache read
// handshake, presents fetched words to the IF/ID latch and applies
// redirects from the resolution stage, dropping stale in-flight fetches.
// Ports:
//   clk, reset_n         : clock, async active-low reset
//   stall                : downstream pipeline stall
//   redirect/redirect_pc : resolved control transfer and its target
//   icache_resp/rdata    : one-cycle read-data-valid pulse and data
//   icache_read/address  : read request (held until resp) and its address
//   if_valid/instr/pc    : fetched instruction, NOP_INSTR when not valid
//   if_pc_plus2          : if_pc + 2
//   squash_count         : saturating count of fetches dropped by redirect
//
// state     | meaning
// S_RESET   | first cycle out of reset, no request
// S_FETCH   | request outstanding at pc
// S_HOLD    | response parked in hold buffer until stall drops
// S_DISCARD | stale request still in flight at discard_addr; pc = new target
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter lc3b_word RESET_PC  = 16'h0000,
  parameter lc3b_word NOP_INSTR = 16'h0000
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     stall,
  input  logic     redirect,
  input  lc3b_word redirect_pc,
  input  logic     icache_resp,
  input  lc3b_word icache_rdata,
  output logic     icache_read,
  output lc3b_word icache_address,
  output logic     if_valid,
  output lc3b_word if_instr,
  output lc3b_word if_pc,
  output lc3b_word if_pc_plus2,
  output lc3b_word squash_count
);

  fetch_state_t state, state_nxt;
  lc3b_word     pc, pc_nxt;
  lc3b_word     discard_addr, discard_addr_nxt;
  logic         if_valid_nxt;
  lc3b_word     if_instr_nxt, if_pc_nxt;
  logic         squash_inc;
  logic         hold_load, hold_clear, hold_valid;
  fetch_word_t  hold_word;

  fetch_pc_unit_hold_buffer u_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (hold_load),
    .clear   (hold_clear),
    .capture ('{instr: icache_rdata, pc: pc}),
    .valid   (hold_valid),
    .word    (hold_word)
  );

  // The stale request must keep its original address on the bus until the
  // cache answers, even though pc already holds the redirect target.
  assign icache_read    = (state == S_FETCH) || (state == S_DISCARD);
  assign icache_address = (state == S_DISCARD) ? discard_addr : pc;
  assign if_pc_plus2    = pc_incr(if_pc);

  always_comb begin
    state_nxt        = state;
    pc_nxt           = pc;
    discard_addr_nxt = discard_addr;
    if_valid_nxt     = if_valid;
    if_instr_nxt     = if_instr;
    if_pc_nxt        = if_pc;
    squash_inc       = 1'b0;
    hold_load        = 1'b0;
    hold_clear       = 1'b0;

    if (state == S_RESET) begin
      state_nxt = S_FETCH;
      if (!stall) begin
        if_valid_nxt = 1'b0;
        if_instr_nxt = NOP_INSTR;
      end
    end else if (!stall && redirect) begin
      pc_nxt       = {redirect_pc[15:1], 1'b0};
      if_valid_nxt = 1'b0;
      if_instr_nxt = NOP_INSTR;
      hold_clear   = 1'b1;
      if (state == S_FETCH && !icache_resp) begin
        state_nxt        = S_DISCARD;
        discard_addr_nxt = pc;
        squash_inc       = 1'b1;
      end else if (state == S_DISCARD && !icache_resp) begin
        // Already waiting out a dropped fetch: retarget only.
        state_nxt = S_DISCARD;
      end else begin
        state_nxt  = S_FETCH;
        squash_inc = 1'b1;
      end
    end else begin
      unique case (state)
        S_FETCH: begin
          if (icache_resp && !stall) begin
            if_instr_nxt = icache_rdata;
            if_pc_nxt    = pc;
            if_valid_nxt = 1'b1;
            pc_nxt       = pc_incr(pc);
          end else if (icache_resp) begin
            hold_load = 1'b1;
            state_nxt = S_HOLD;
          end else if (!stall) begin
            if_valid_nxt = 1'b0;
            if_instr_nxt = NOP_INSTR;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            hold_clear = 1'b1;
            state_nxt  = S_FETCH;
            if (hold_valid) begin
              if_instr_nxt = hold_word.instr;
              if_pc_nxt    = hold_word.pc;
              if_valid_nxt = 1'b1;
              pc_nxt       = pc_incr(pc);
            end else begin
              if_valid_nxt = 1'b0;
              if_instr_nxt = NOP_INSTR;
            end
          end
        end
        S_DISCARD: begin
          if (icache_resp) begin
            state_nxt = S_FETCH;
          end
          if (!stall) begin
            if_valid_nxt = 1'b0;
            if_instr_nxt = NOP_INSTR;
          end
        end
        default: begin
          state_nxt = S_RESET;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_RESET;
      pc           <= RESET_PC;
      discard_addr <= RESET_PC;
      if_valid     <= 1'b0;
      if_instr     <= NOP_INSTR;
      if_pc        <= RESET_PC;
      squash_count <= '0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      discard_addr <= discard_addr_nxt;
      if_valid     <= if_valid_nxt;
      if_instr     <= if_instr_nxt;
      if_pc        <= if_pc_nxt;
      if (squash_inc && (squash_count != 16'hFFFF)) begin
        squash_count <= squash_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        icache_resp;
  logic [15:0] icache_rdata;
  logic        icache_read;
  logic [15:0] icache_address;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
  logic [15:0] squash_count;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_pc_unit #(
    .RESET_PC  (16'h0000),
    .NOP_INSTR (16'h0000)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .icache_resp    (icache_resp),
    .icache_rdata   (icache_rdata),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus2    (if_pc_plus2),
    .squash_count   (squash_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are applied on a negedge; the expected outputs are the ones
  // visible in that same cycle (i.e. the result of the previous vectors).
  typedef struct {
    logic        stall;
    logic        redirect;
    logic [15:0] rpc;
    logic        resp;
    logic [15:0] rdata;
    logic        e_read;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [15:0] e_pc;
    logic [15:0] e_sq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic rd, input logic [15:0] rpc,
                     input logic rsp, input logic [15:0] rdata,
                     input logic e_read, input logic [15:0] e_addr,
                     input logic e_valid, input logic [15:0] e_instr,
                     input logic [15:0] e_pc, input logic [15:0] e_sq);
    vec_t v;
    v.stall = st;  v.redirect = rd; v.rpc = rpc; v.resp = rsp; v.rdata = rdata;
    v.e_read = e_read; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pc = e_pc; v.e_sq = e_sq;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [step %0d]: got %h, expected %h", name, idx, act, exp);
  endtask

  task automatic drive(input logic st, input logic rd, input logic [15:0] rpc,
                       input logic rsp, input logic [15:0] rdata);
    stall = st; redirect = rd; redirect_pc = rpc;
    icache_resp = rsp; icache_rdata = rdata;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 16'h0000, 0, 16'h0000);

    //  st rd rpc      rsp rdata     read addr     vld instr     pc       squash
    add(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'd0); // 0 S_RESET
    add(0, 0, 16'h0000, 1, 16'h1111, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'd0); // 1 word A
    add(0, 0, 16'h0000, 1, 16'h2222, 1, 16'h0002, 1, 16'h1111, 16'h0000, 16'd0); // 2 word B
    add(0, 0, 16'h0000, 1, 16'h3333, 1, 16'h0004, 1, 16'h2222, 16'h0002, 16'd0); // 3 word C
    add(0, 1, 16'h0011, 1, 16'hDEAD, 1, 16'h0006, 1, 16'h3333, 16'h0004, 16'd0); // 4 redirect+resp, bit0 forced
    add(1, 0, 16'h0000, 1, 16'h5555, 1, 16'h0010, 0, 16'h0000, 16'h0000, 16'd1); // 5 resp X under stall
    add(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'd1); // 6 S_HOLD
    add(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'd1); // 7 S_HOLD
    add(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'd1); // 8 stall drops
    add(0, 1, 16'h0020, 1, 16'hBEEF, 1, 16'h0012, 1, 16'h5555, 16'h0010, 16'd1); // 9 X out, redirect 0020
    add(0, 1, 16'h0200, 0, 16'h0000, 1, 16'h0020, 0, 16'h0000, 16'h0000, 16'd2); // 10 redirect while pending
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0020, 0, 16'h0000, 16'h0000, 16'd3); // 11 S_DISCARD
    add(0, 0, 16'h0000, 1, 16'hBAD0, 1, 16'h0020, 0, 16'h0000, 16'h0000, 16'd3); // 12 stale resp
    add(0, 0, 16'h0000, 1, 16'h7777, 1, 16'h0200, 0, 16'h0000, 16'h0000, 16'd3); // 13 fetch target
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0202, 1, 16'h7777, 16'h0200, 16'd3); // 14 first valid at 0200
    add(1, 1, 16'h0300, 0, 16'h0000, 1, 16'h0202, 0, 16'h0000, 16'h0000, 16'd3); // 15 redirect under stall
    add(0, 1, 16'h0300, 1, 16'hDEAD, 1, 16'h0202, 0, 16'h0000, 16'h0000, 16'd3); // 16 redirect+resp
    add(0, 0, 16'h0000, 1, 16'h8888, 1, 16'h0300, 0, 16'h0000, 16'h0000, 16'd4); // 17 fetch 0300
    add(0, 1, 16'hFFFE, 0, 16'h0000, 1, 16'h0302, 1, 16'h8888, 16'h0300, 16'd4); // 18 redirect FFFE
    add(0, 1, 16'hFFFE, 0, 16'h0000, 1, 16'h0302, 0, 16'h0000, 16'h0000, 16'd5); // 19 re-redirect in discard
    add(0, 0, 16'h0000, 1, 16'hBAD1, 1, 16'h0302, 0, 16'h0000, 16'h0000, 16'd5); // 20 stale resp
    add(0, 0, 16'h0000, 1, 16'h9999, 1, 16'hFFFE, 0, 16'h0000, 16'h0000, 16'd5); // 21 fetch FFFE
    add(0, 0, 16'h0000, 1, 16'hAAAA, 1, 16'h0000, 1, 16'h9999, 16'hFFFE, 16'd5); // 22 wrapped
    add(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 1, 16'hAAAA, 16'h0000, 16'd5); // 23 stall, no resp
    add(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 1, 16'hAAAA, 16'h0000, 16'd5); // 24 outputs held

    #1;
    check("reset_read",   -1, {15'd0, icache_read}, 16'd0);
    check("reset_valid",  -1, {15'd0, if_valid},    16'd0);
    check("reset_instr",  -1, if_instr,             16'h0000);
    check("reset_pc",     -1, if_pc,                16'h0000);
    check("reset_squash", -1, squash_count,         16'd0);

    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].resp, vecs[i].rdata);
      #1;
      check("icache_read", i, {15'd0, icache_read}, {15'd0, vecs[i].e_read});
      if (vecs[i].e_read)
        check("icache_address", i, icache_address, vecs[i].e_addr);
      check("if_valid", i, {15'd0, if_valid}, {15'd0, vecs[i].e_valid});
      check("if_instr", i, if_instr, vecs[i].e_instr);
      if (vecs[i].e_valid) begin
        check("if_pc", i, if_pc, vecs[i].e_pc);
        check("if_pc_plus2", i, if_pc_plus2, vecs[i].e_pc + 16'd2);
      end
      check("squash_count", i, squash_count, vecs[i].e_sq);
      @(negedge clk);
    end

    // Reset pulsed while a request is outstanding (state is S_FETCH at 0002).
    drive(0, 0, 16'h0000, 0, 16'h0000);
    #1;
    check("pre_reset_read", 100, {15'd0, icache_read}, 16'd1);
    reset_n = 1'b0;
    #1;
    check("midreset_read",   101, {15'd0, icache_read}, 16'd0);
    check("midreset_valid",  101, {15'd0, if_valid},    16'd0);
    check("midreset_squash", 101, squash_count,         16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_reset_read", 102, {15'd0, icache_read}, 16'd0);
    @(negedge clk);
    #1;
    check("post_reset_read", 103, {15'd0, icache_read}, 16'd1);
    check("post_reset_addr", 103, icache_address,       16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
